sms32_41_inv_seq: RTL and testbench

- Multi-cycle inverse S-box engine for the SMS32 power-41 S-box over GF(2^6).
- Uses 41^6 ≡ 1 (mod 63), so x^20 = x^(41^5) is the exact inverse of the x^41 map.
- Maps the input into the tower basis once (isomorphism), applies one power_41 core per clock for N iterations, and maps back once (inv_isomorphism).
- One core instance is shared across all modes. Sits on the decrypt side of the SMS32 datapath and uses valid/ready handshakes on both ends.

---
 rtl/sms32_41_inv_seq.sv | 134 +++++++++++++
 tb/tb_sms32_41_inv_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sms32_41_inv_seq.sv
// Iterative x^41 engine over GF(2^6): one tower-field core applied N times gives x^(41^N),
// so five passes (mode 01) produce the inverse S-box x^20 because 41^6 = 1 mod 63.
module sms32_41_inv_seq #(
   parameter int W     = 6,
   parameter int CNT_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     w_q, w_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   // Tower field: GF(8) = GF(2)[z]/(z^3+z+1), extended by y^2 = y + 1; bits [5:3] hold the y coefficient.
   function automatic logic [2:0] gf8Mul(input logic [2:0] a, input logic [2:0] b);
      logic [4:0] c;
      c[0] = a[0] & b[0];
      c[1] = (a[0] & b[1]) ^ (a[1] & b[0]);
      c[2] = (a[0] & b[2]) ^ (a[1] & b[1]) ^ (a[2] & b[0]);
      c[3] = (a[1] & b[2]) ^ (a[2] & b[1]);
      c[4] = a[2] & b[2];
      return {c[2] ^ c[4], c[1] ^ c[3] ^ c[4], c[0] ^ c[3]};
   endfunction

   function automatic logic [2:0] gf8Sq(input logic [2:0] a);
      return {a[1] ^ a[2], a[2], a[0]};
   endfunction

   function automatic logic [5:0] towMul(input logic [5:0] a, input logic [5:0] b);
      logic [2:0] hh;
      hh = gf8Mul(a[5:3], b[5:3]);
      return {hh ^ gf8Mul(a[5:3], b[2:0]) ^ gf8Mul(a[2:0], b[5:3]),
              hh ^ gf8Mul(a[2:0], b[2:0])};
   endfunction

   function automatic logic [5:0] towSq(input logic [5:0] a);
      logic [2:0] h2;
      h2 = gf8Sq(a[5:3]);
      return {h2, h2 ^ gf8Sq(a[2:0])};
   endfunction

   function automatic logic [5:0] power41(input logic [5:0] t);
      logic [5:0] t8, t32;
      t8  = towSq(towSq(towSq(t)));
      t32 = towSq(towSq(t8));
      return towMul(towMul(t32, t8), t);
   endfunction

   // Standard basis is GF(2)[a]/(a^6+a+1); z maps to a^27 and y to a^21.
   function automatic logic [5:0] iso(input logic [5:0] s);
      return {s[2] ^ s[3] ^ s[4],
              s[1] ^ s[3] ^ s[4] ^ s[5],
              s[5],
              s[4] ^ s[5],
              s[1] ^ s[4],
              s[0] ^ s[1] ^ s[2] ^ s[4] ^ s[5]};
   endfunction

   function automatic logic [5:0] invIso(input logic [5:0] t);
      return {t[3],
              t[2] ^ t[3],
              t[1] ^ t[3] ^ t[4],
              t[1] ^ t[2] ^ t[4] ^ t[5],
              t[1] ^ t[2] ^ t[3],
              t[0] ^ t[2] ^ t[3] ^ t[4] ^ t[5]};
   endfunction

   function automatic logic [CNT_W-1:0] iterCount(input logic [1:0] m);
      case (m)
         2'b00:   return CNT_W'(1);
         2'b01:   return CNT_W'(5);
         2'b10:   return CNT_W'(3);
         default: return CNT_W'(2);
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
      end
   end

   assign accept = in_valid & in_ready;

   // A result consumed in DONE may be replaced by a new operand on the same edge.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = ITER;
               w_d     = iso(in_data);
               cnt_d   = iterCount(mode);
            end else if (state_q == DONE && out_ready) begin
               state_d = IDLE;
            end
         end
         ITER: begin
            w_d   = power41(w_q);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
      out_valid = (state_q == DONE);
      busy      = (state_q == ITER) || (state_q == DONE);
      out_data  = (state_q == DONE) ? invIso(w_q) : '0;
   end

endmodule

// File: tb/tb_sms32_41_inv_seq.sv
// Directed bench for sms32_41_inv_seq: hand-computed vector table plus sequences for
// round trip, field inverse, backpressure, mode latching and mid-operation reset.
module tb_sms32_41_inv_seq;

   logic       clk;
   logic       rst;
   logic       inValid;
   logic       inReady;
   logic [5:0] inData;
   logic [1:0] mode;
   logic       outValid;
   logic       outReady;
   logic [5:0] outData;
   logic       busy;

   int vecCount;
   int missCount;

   typedef struct {
      logic [5:0] x;
      logic [1:0] m;
      logic [5:0] expData;
      int         expLat;
   } vec_t;

   vec_t vecs [19];

   sms32_41_inv_seq #(.W(6), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .mode      (mode),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference arithmetic in the standard polynomial basis a^6 = a + 1.
   function automatic logic [5:0] gfMulRef(input logic [5:0] a, input logic [5:0] b);
      logic [5:0] acc = '0;
      logic [5:0] sh  = a;
      for (int i = 0; i < 6; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[5] ? ({sh[4:0], 1'b0} ^ 6'h03) : {sh[4:0], 1'b0};
      end
      return acc;
   endfunction

   function automatic logic [5:0] powRef(input logic [5:0] x, input int e);
      logic [5:0] r = 6'h01;
      for (int i = 0; i < e; i++) r = gfMulRef(r, x);
      return r;
   endfunction

   task automatic applyStimulus(input logic v, input logic [5:0] d, input logic [1:0] m, input logic r);
      inValid  = v;
      inData   = d;
      mode     = m;
      outReady = r;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Called on the negedge after the accept edge; returns on the negedge where out_valid is seen.
   task automatic waitResult(output int edges, output logic [5:0] res);
      edges = 0;
      while (!outValid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      res = outData;
   endtask

   task automatic runOp(input logic [5:0] x, input logic [1:0] m, input int expLat,
                        input string tag, output logic [5:0] res);
      int edges;
      applyStimulus(1'b1, x, m, 1'b1);
      checkOutput({tag, " in_ready"}, inReady, 1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 6'h00, m, 1'b1);
      waitResult(edges, res);
      checkOutput({tag, " latency"}, edges, expLat);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] res, f, g;
      int         edges;
      logic       sawValid;

      vecCount  = 0;
      missCount = 0;
      vecs[0]  = '{6'h00, 2'b01, 6'h00, 5};
      vecs[1]  = '{6'h01, 2'b10, 6'h01, 3};
      vecs[2]  = '{6'h02, 2'b00, 6'h1D, 1};
      vecs[3]  = '{6'h02, 2'b01, 6'h3C, 5};
      vecs[4]  = '{6'h02, 2'b10, 6'h21, 3};
      vecs[5]  = '{6'h02, 2'b11, 6'h37, 2};
      vecs[6]  = '{6'h04, 2'b00, 6'h1E, 1};
      vecs[7]  = '{6'h04, 2'b01, 6'h2F, 5};
      vecs[8]  = '{6'h04, 2'b10, 6'h31, 3};
      vecs[9]  = '{6'h04, 2'b11, 6'h29, 2};
      vecs[10] = '{6'h20, 2'b00, 6'h13, 1};
      vecs[11] = '{6'h20, 2'b01, 6'h2C, 5};
      vecs[12] = '{6'h20, 2'b10, 6'h3F, 3};
      vecs[13] = '{6'h20, 2'b11, 6'h07, 2};
      vecs[14] = '{6'h3F, 2'b00, 6'h27, 1};
      vecs[15] = '{6'h3F, 2'b01, 6'h07, 5};
      vecs[16] = '{6'h03, 2'b11, 6'h03, 2};
      vecs[17] = '{6'h01, 2'b01, 6'h01, 5};
      vecs[18] = '{6'h00, 2'b10, 6'h00, 3};

      rst = 1'b0;
      applyStimulus(1'b0, 6'h00, 2'b00, 1'b0);
      #1 rst = 1'b1;
      #1;
      checkOutput("reset in_ready", inReady, 1);
      checkOutput("reset out_valid", outValid, 0);
      checkOutput("reset out_data", outData, 0);
      checkOutput("reset busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle in_ready", inReady, 1);

      for (int i = 0; i < 19; i++) begin
         runOp(vecs[i].x, vecs[i].m, vecs[i].expLat, $sformatf("vec%0d", i), res);
         checkOutput($sformatf("vec%0d data", i), res, vecs[i].expData);
      end

      for (int x = 0; x < 64; x++) begin
         runOp(6'(x), 2'b00, 1, $sformatf("fwd x=%0h", x), f);
         checkOutput($sformatf("fwd x=%0h data", x), f, powRef(6'(x), 41));
         runOp(f, 2'b01, 5, $sformatf("inv x=%0h", x), res);
         checkOutput($sformatf("roundtrip x=%0h", x), res, x);
      end

      for (int x = 0; x < 64; x++) begin
         runOp(6'(x), 2'b10, 3, $sformatf("finv x=%0h", x), g);
         checkOutput($sformatf("finv x=%0h data", x), g, powRef(6'(x), 62));
         runOp(g, 2'b10, 3, $sformatf("finv2 x=%0h", x), res);
         checkOutput($sformatf("finv2 x=%0h data", x), res, x);
      end

      // Backpressure then back-to-back handoff on the same edge.
      applyStimulus(1'b1, 6'h02, 2'b01, 1'b0);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 6'h00, 2'b01, 1'b0);
      waitResult(edges, res);
      checkOutput("bp latency", edges, 5);
      for (int c = 0; c < 10; c++) begin
         checkOutput($sformatf("bp hold data c%0d", c), outData, 6'h3C);
         checkOutput($sformatf("bp in_ready c%0d", c), inReady, 0);
         @(negedge clk);
      end
      checkOutput("bp still valid", outValid, 1);
      applyStimulus(1'b1, 6'h04, 2'b01, 1'b1);
      #1;
      checkOutput("b2b in_ready", inReady, 1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 6'h00, 2'b00, 1'b1);
      checkOutput("b2b out_valid drop", outValid, 0);
      checkOutput("b2b busy", busy, 1);
      waitResult(edges, res);
      checkOutput("b2b latency", edges, 5);
      checkOutput("b2b data", res, 6'h2F);
      @(posedge clk);
      @(negedge clk);

      // Mode changes after accept must not alter the operation.
      applyStimulus(1'b1, 6'h20, 2'b01, 1'b1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 6'h00, 2'b00, 1'b1);
      waitResult(edges, res);
      checkOutput("latch latency", edges, 5);
      checkOutput("latch data", res, powRef(6'h20, 20));
      @(posedge clk);
      @(negedge clk);

      // Reset in the third ITER cycle aborts the request asynchronously.
      applyStimulus(1'b1, 6'h04, 2'b01, 1'b1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 6'h00, 2'b01, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort in_ready", inReady, 1);
      checkOutput("abort out_valid", outValid, 0);
      checkOutput("abort out_data", outData, 0);
      checkOutput("abort busy", busy, 0);
      sawValid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (outValid) sawValid = 1'b1;
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (outValid) sawValid = 1'b1;
      end
      checkOutput("abort no pulse", sawValid, 0);
      runOp(6'h04, 2'b01, 5, "post-reset", res);
      checkOutput("post-reset data", res, 6'h2F);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
